// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid register: handshake state encoding and the MIPS nop word.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [31:0] PIPE_NOP = 32'h0;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// One valid/ready/data channel; master drives payload, slave answers with ready.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one skid entry,
// synchronous flush to a bubble and a saturating stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter int unsigned       STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   clr_stats,
  pipe_skid_reg_if.slave         in_if,
  pipe_skid_reg_if.master        out_if,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, w_main_nxt;
  logic [DATA_W-1:0] r_skid, w_skid_nxt;
  logic              r_in_ready;
  logic              w_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_xfer   = in_if.valid & r_in_ready;
  assign w_out_xfer  = w_out_valid & out_if.ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_main_nxt  = in_if.data;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_nxt = in_if.data;
        end else if (w_in_xfer) begin
          w_skid_nxt  = in_if.data;
          w_state_nxt = FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_xfer) begin
          w_main_nxt  = r_skid;
          w_state_nxt = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush overrides whatever the handshake decided, dropping any same-cycle input.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = RESET_VAL;
      w_skid_nxt  = RESET_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_main     <= RESET_VAL;
      r_skid     <= RESET_VAL;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  assign in_if.ready  = r_in_ready;
  assign out_if.valid = w_out_valid;
  assign out_if.data  = r_main;

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_out_valid & ~out_if.ready),
    .clr (clr_stats),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and random checks of pipe_skid_reg: reset, streaming, backpressure, flush, stall counter.
module tb_pipe_skid_reg;

  localparam logic [63:0] RV = 64'hFFFF_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, clr_stats = 1'b0;
  logic clr2 = 1'b0;
  logic [15:0] stall_cnt;
  logic [3:0]  stall2;

  int tests = 0;
  int fails = 0;

  pipe_skid_reg_if #(.DATA_W(64)) a_in ();
  pipe_skid_reg_if #(.DATA_W(64)) a_out ();
  pipe_skid_reg_if #(.DATA_W(8))  b_in ();
  pipe_skid_reg_if #(.DATA_W(8))  b_out ();

  pipe_skid_reg #(.DATA_W(64), .RESET_VAL(RV), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats),
    .in_if(a_in), .out_if(a_out), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(8), .RESET_VAL(8'h00), .STALL_CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0), .clr_stats(clr2),
    .in_if(b_in), .out_if(b_out), .stall_cnt(stall2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
    tick();
    tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", a_out.valid); end
    tests++; if (a_in.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", a_in.ready); end
    tests++; if (a_out.data !== RV) begin fails++; $display("FAIL reset_data got %h exp %h", a_out.data, RV); end
    tests++; if (stall2 !== 4'd0) begin fails++; $display("FAIL reset_stall2 got %0d exp 0", stall2); end
    rst = 1'b0;
    a_in.valid = 1'b1; a_in.data = 64'hA;
    tick();
    a_in.data = 64'hB;
    tick();
    a_in.valid = 1'b0;
    tests++; if (a_in.ready !== 1'b0 || a_out.data !== 64'hA || stall_cnt !== 16'd1) begin
      fails++; $display("FAIL full_before_rst got rdy=%b data=%h cnt=%0d exp rdy=0 data=a cnt=1", a_in.ready, a_out.data, stall_cnt);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid got %b exp 0", a_out.valid); end
    tests++; if (a_in.ready !== 1'b1) begin fails++; $display("FAIL async_rst_ready got %b exp 1", a_in.ready); end
    tests++; if (a_out.data !== RV) begin fails++; $display("FAIL async_rst_data got %h exp %h", a_out.data, RV); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL async_rst_cnt got %0d exp 0", stall_cnt); end
    #1 rst = 1'b0;
    a_in.valid = 1'b1; a_in.data = 64'h3C; a_out.ready = 1'b1;
    tick();
    a_in.valid = 1'b0;
    tests++; if (a_out.valid !== 1'b1 || a_out.data !== 64'h3C) begin
      fails++; $display("FAIL post_rst_accept got v=%b data=%h exp v=1 data=3c", a_out.valid, a_out.data);
    end
    tick();
    tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL post_rst_drain got %b exp 0", a_out.valid); end
  endtask

  task automatic test_stream();
    a_out.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in.valid = 1'b1; a_in.data = 64'(i);
      tick();
      tests++; if (a_out.valid !== 1'b1 || a_out.data !== 64'(i) || a_in.ready !== 1'b1) begin
        fails++; $display("FAIL stream_%0d got v=%b data=%h rdy=%b exp v=1 data=%h rdy=1", i, a_out.valid, a_out.data, a_in.ready, 64'(i));
      end
    end
    a_in.valid = 1'b0;
    tick();
    tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL stream_end got %b exp 0", a_out.valid); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stream_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 64'h10;
    tick();
    tests++; if (a_in.ready !== 1'b1 || a_out.data !== 64'h10) begin
      fails++; $display("FAIL b2b_c1 got rdy=%b data=%h exp rdy=1 data=10", a_in.ready, a_out.data);
    end
    a_in.data = 64'h11;
    tick();
    tests++; if (a_in.ready !== 1'b0) begin fails++; $display("FAIL b2b_c2_ready got %b exp 0", a_in.ready); end
    a_in.data = 64'h12;
    tick();
    tick();
    tests++; if (a_out.data !== 64'h10 || a_in.ready !== 1'b0 || stall_cnt !== 16'd3) begin
      fails++; $display("FAIL b2b_hold got data=%h rdy=%b cnt=%0d exp data=10 rdy=0 cnt=3", a_out.data, a_in.ready, stall_cnt);
    end
    a_out.ready = 1'b1;
    tick();
    tests++; if (a_out.data !== 64'h11 || a_in.ready !== 1'b1) begin
      fails++; $display("FAIL b2b_skid got data=%h rdy=%b exp data=11 rdy=1", a_out.data, a_in.ready);
    end
    tick();
    a_in.valid = 1'b0;
    tests++; if (a_out.data !== 64'h12 || a_out.valid !== 1'b1) begin
      fails++; $display("FAIL b2b_third got v=%b data=%h exp v=1 data=12", a_out.valid, a_out.data);
    end
    tick();
    tests++; if (a_out.valid !== 1'b0 || stall_cnt !== 16'd3) begin
      fails++; $display("FAIL b2b_end got v=%b cnt=%0d exp v=0 cnt=3", a_out.valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 64'h30;
    tick();
    a_in.data = 64'h31;
    tick();
    flush = 1'b1; a_in.data = 64'h20;
    tick();
    flush = 1'b0; a_in.valid = 1'b0;
    tests++; if (a_out.valid !== 1'b0 || a_in.ready !== 1'b1 || a_out.data !== RV) begin
      fails++; $display("FAIL flush_state got v=%b rdy=%b data=%h exp v=0 rdy=1 data=%h", a_out.valid, a_in.ready, a_out.data, RV);
    end
    tests++; if (stall_cnt !== 16'd5) begin fails++; $display("FAIL flush_cnt got %0d exp 5", stall_cnt); end
    a_out.ready = 1'b1;
    tick();
    tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL flush_no_skid got %b exp 0", a_out.valid); end
    a_in.valid = 1'b1; a_in.data = 64'h21;
    tick();
    a_in.valid = 1'b0;
    tests++; if (a_out.valid !== 1'b1 || a_out.data !== 64'h21) begin
      fails++; $display("FAIL flush_next got v=%b data=%h exp v=1 data=21", a_out.valid, a_out.data);
    end
    tick();
    tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL flush_drain got %b exp 0", a_out.valid); end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL clr_stats got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_saturation();
    b_out.ready = 1'b0;
    b_in.valid = 1'b1; b_in.data = 8'h05;
    tick();
    b_in.valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14 || k == 15 || k == 20) begin
        tests++; if (stall2 !== 4'((k > 15) ? 15 : k)) begin
          fails++; $display("FAIL sat_%0d got %0d exp %0d", k, stall2, (k > 15) ? 15 : k);
        end
      end
    end
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    tests++; if (stall2 !== 4'd0) begin fails++; $display("FAIL sat_clr got %0d exp 0", stall2); end
    tick();
    tests++; if (stall2 !== 4'd1) begin fails++; $display("FAIL sat_after_clr got %0d exp 1", stall2); end
    b_out.ready = 1'b1;
    tick();
    tests++; if (b_out.valid !== 1'b0) begin fails++; $display("FAIL sat_drain got %b exp 0", b_out.valid); end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        ix, ox;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 10000; c++) begin
      tests++; if (a_out.valid !== (q.size() != 0) || a_in.ready !== (q.size() < 2)) begin
        fails++; $display("FAIL rnd_ctrl_%0d got v=%b rdy=%b exp entries=%0d", c, a_out.valid, a_in.ready, q.size());
      end
      if (q.size() != 0) begin
        tests++; if (a_out.data !== q[0]) begin
          fails++; $display("FAIL rnd_data_%0d got %h exp %h", c, a_out.data, q[0]);
        end
      end
      if (prev_stall) begin
        tests++; if (a_out.data !== prev_data || a_out.valid !== 1'b1) begin
          fails++; $display("FAIL rnd_stable_%0d got v=%b data=%h exp v=1 data=%h", c, a_out.valid, a_out.data, prev_data);
        end
      end
      a_in.valid   = 1'($urandom_range(0, 1));
      a_in.data    = {$urandom, $urandom};
      a_out.ready  = 1'($urandom_range(0, 1));
      ix = a_in.valid & a_in.ready;
      ox = a_out.valid & a_out.ready;
      prev_stall = a_out.valid & ~a_out.ready;
      prev_data  = a_out.data;
      if (ox && q.size() != 0) void'(q.pop_front());
      if (ix) q.push_back(a_in.data);
      tick();
    end
    a_in.valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised inter-stage pipeline register for the pipelined MIPS CPU. It supersedes the plain enable-gated stage registers with a valid/ready handshake, a two-entry skid buffer and a synchronous flush that inserts a bubble. A saturating stall counter supports performance analysis. The block is instantiated between any two pipeline stages (IF/ID, ID/EX, …) with the payload width set per stage.

## Interface
Parameters:
- DATA_W, 64: payload width in bits (e.g. Instr + PCPlus4 = 64).
- RESET_VAL, {DATA_W{1'b0}}: payload value after reset or flush. All-zero is a MIPS nop.
- STALL_CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous bubble insert; highest priority after rst.
- clr_stats  in  1  synchronous clear of stall_cnt.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  block can accept; driven from a register, with no combinational path from out_ready.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload valid to downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload, driven directly from the main register.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Data order is preserved and nothing is duplicated or dropped, except on flush.
- Storage: main register (drives out_data) and skid register.
- State machine:
  - EMPTY: in_ready=1, out_valid=0. Input transfer loads main and moves to BUSY.
  - BUSY: in_ready=1, out_valid=1.
    - Input and output transfer together: main ← in_data, stay in BUSY.
    - Input transfer only: skid ← in_data, move to FULL.
    - Output transfer only: move to EMPTY.
    - Neither: hold.
  - FULL: in_ready=0, out_valid=1. Output transfer: main ← skid, move to BUSY. Otherwise hold; in_valid is ignored.
- in_ready is a registered copy of (next_state != FULL).
- Flush:
  - Next state is EMPTY; main and skid ← RESET_VAL.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle counts as completed by the consumer.
  - The cycle after a flush has out_valid=0 and in_ready=1.
- Stall counter:
  - Increments each cycle with out_valid & !out_ready, saturating at 2^STALL_CNT_W−1.
  - clr_stats sets it to 0, overriding the increment in the same cycle.
  - flush does not affect it.
- Legacy mapping: the old stall enable En maps to out_ready. The old synchronous rst maps to flush.

## Timing
- Reset values: state EMPTY, in_ready=1, out_valid=0, out_data=RESET_VAL, skid=RESET_VAL, stall_cnt=0. All take effect asynchronously on rst.
- Latency: an input transfer at edge N gives out_valid=1 with that payload after edge N.
- Throughput: one transfer per cycle with out_ready held high. The skid entry is never used in that case.
- Backpressure: after out_ready falls, at most one more input transfer is accepted, into skid. in_ready drops the following cycle.
- Reset mid-operation discards both entries. The first post-reset edge with in_valid=1 is accepted.
- Priority order: rst > flush > normal handshakes. clr_stats is independent of flush.

## Structure
- Package pipe_pkg holds:
  - the state typedef pipe_state_t {EMPTY, BUSY, FULL};
  - localparam PIPE_NOP = 32'h0, for RESET_VAL composition.
- One sub-module is natural: sat_counter (parameter W; inputs inc, clr; async rst), used for stall_cnt.

## Test plan
- Reset while FULL with payloads 0xA, 0xB -> out_valid=0, in_ready=1, out_data=RESET_VAL, stall_cnt=0 immediately, with no clock edge required.
- Stream 0x1…0x8, one per cycle, out_ready=1 -> out_data emits 0x1…0x8 on consecutive cycles, one cycle after each is accepted; stall_cnt stays 0.
- Send 0x10, 0x11, 0x12 back-to-back; out_ready=0 for 3 cycles, then 1 -> 0x10 held, 0x11 in skid, in_ready=0 from the third cycle, 0x12 held upstream; output order 0x10, 0x11, 0x12; stall_cnt=3.
- Flush while FULL with in_valid=1 (0x20) -> next cycle out_valid=0, in_ready=1, out_data=RESET_VAL; 0x20 never appears on the output.
- STALL_CNT_W=4 with 20 stalled cycles -> stall_cnt saturates at 15. Assert clr_stats together with a stall -> stall_cnt=0 next cycle.
- Random valid/ready (10k cycles, DATA_W=64) against a reference FIFO model -> output sequence identical, no payload changes while out_valid=1 and out_ready=0.
